// File: rtl/lcd_text_driver.sv
// HD44780 16x2 text driver: runs the power-up/init sequence, then repaints both
// lines whenever the right-justified, NUL-padded text bus changes.
module lcd_text_driver #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int EN_HIGH_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [255:0] lcd_text,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic         lcd_on,
  output logic         lcd_blon,
  output logic         init_done,
  output logic         busy
);

  localparam int CMD_TOTAL   = 1 + EN_HIGH_CYCLES + CMD_WAIT_CYCLES;
  localparam int CLEAR_TOTAL = 1 + EN_HIGH_CYCLES + CLEAR_WAIT_CYCLES;
  localparam int MAX_A       = (POWERUP_CYCLES > CLEAR_TOTAL) ? POWERUP_CYCLES : CLEAR_TOTAL;
  localparam int MAX_COUNT   = (MAX_A > CMD_TOTAL) ? MAX_A : CMD_TOTAL;
  localparam int CW          = $clog2(MAX_COUNT + 1);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SNAP, LINE1, CHARS1, LINE2, CHARS2} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic [4:0]     pos_reg;
  logic [1:0]     init_idx_reg;
  logic [255:0]   snap_reg;
  logic [5:0]     lead_reg;
  logic           dirty_reg;
  logic           init_done_reg;

  logic [7:0]     slot [32];
  logic [31:0]    text_nul;
  logic [5:0]     lead_calc;
  logic [5:0]     src;
  logic [7:0]     char_byte;
  logic [7:0]     wr_data;
  logic           wr_rs;
  logic           write_state;
  logic           write_last;
  logic           pwrup_last;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_slot
      assign slot[gi]     = snap_reg[255-8*gi -: 8];
      assign text_nul[gi] = (lcd_text[255-8*gi -: 8] == 8'h00);
    end
  endgenerate

  // Index of the first non-NUL slot; 32 when the whole bus is NUL.
  always_comb begin
    lead_calc = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (!text_nul[i]) lead_calc = 6'(i);
    end
  end

  assign src       = {1'b0, pos_reg} + lead_reg;
  assign char_byte = (src[5] || slot[src[4:0]] == 8'h00) ? 8'h20 : slot[src[4:0]];

  assign write_state = (state_reg == INIT) || (state_reg == LINE1) || (state_reg == CHARS1) ||
                       (state_reg == LINE2) || (state_reg == CHARS2);
  assign write_last  = (wr_data == 8'h01 && !wr_rs) ? (cnt_reg == CW'(CLEAR_TOTAL - 1))
                                                    : (cnt_reg == CW'(CMD_TOTAL - 1));
  assign pwrup_last  = (cnt_reg == CW'(POWERUP_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) state_reg <= PWRUP;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PWRUP:  if (pwrup_last) state_next = INIT;
      INIT:   if (write_last && init_idx_reg == 2'd3) state_next = IDLE;
      IDLE:   if (dirty_reg || lcd_text != snap_reg) state_next = SNAP;
      SNAP:   state_next = LINE1;
      LINE1:  if (write_last) state_next = CHARS1;
      CHARS1: if (write_last && pos_reg == 5'd15) state_next = LINE2;
      LINE2:  if (write_last) state_next = CHARS2;
      CHARS2: if (write_last && pos_reg == 5'd31) state_next = IDLE;
      default: state_next = PWRUP;
    endcase
  end

  always_comb begin
    wr_data = 8'h00;
    wr_rs   = 1'b0;
    case (state_reg)
      INIT: begin
        case (init_idx_reg)
          2'd0:    wr_data = 8'h38;
          2'd1:    wr_data = 8'h0C;
          2'd2:    wr_data = 8'h01;
          default: wr_data = 8'h06;
        endcase
      end
      LINE1:  wr_data = 8'h80;
      LINE2:  wr_data = 8'hC0;
      CHARS1, CHARS2: begin
        wr_data = char_byte;
        wr_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  assign lcd_data  = wr_data;
  assign lcd_rs    = wr_rs;
  assign lcd_en    = write_state && (cnt_reg != '0) && (cnt_reg <= CW'(EN_HIGH_CYCLES));
  assign lcd_rw    = 1'b0;
  assign lcd_on    = 1'b1;
  assign lcd_blon  = 1'b1;
  assign init_done = init_done_reg;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg       <= '0;
      pos_reg       <= '0;
      init_idx_reg  <= '0;
      snap_reg      <= '0;
      lead_reg      <= '0;
      dirty_reg     <= 1'b1;
      init_done_reg <= 1'b0;
    end else begin
      if (state_reg == PWRUP) cnt_reg <= pwrup_last ? '0 : cnt_reg + 1'b1;
      else if (write_state)   cnt_reg <= write_last ? '0 : cnt_reg + 1'b1;
      else                    cnt_reg <= '0;

      if (state_reg == INIT && write_last) begin
        init_idx_reg <= init_idx_reg + 2'd1;
        if (init_idx_reg == 2'd3) init_done_reg <= 1'b1;
      end

      if (state_reg == SNAP) begin
        snap_reg  <= lcd_text;
        dirty_reg <= 1'b0;
        lead_reg  <= lead_calc;
        pos_reg   <= '0;
      end

      // Position runs 0..31 across both lines; only character writes advance it.
      if ((state_reg == CHARS1 || state_reg == CHARS2) && write_last) pos_reg <= pos_reg + 5'd1;
    end
  end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Randomized and directed bench for lcd_text_driver: captures every bus write
// and compares bytes and write spacing against a model of the expected display.
module tb_lcd_text_driver;
  localparam int PU   = 20;
  localparam int EH   = 2;
  localparam int CWT  = 4;
  localparam int CLW  = 10;
  localparam int NORM = 1 + EH + CWT;
  localparam int CLR  = 1 + EH + CLW;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] lcd_text = '0;
  logic [7:0]   lcd_data;
  logic         lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, init_done, busy;

  lcd_text_driver #(
    .POWERUP_CYCLES(PU), .EN_HIGH_CYCLES(EH),
    .CMD_WAIT_CYCLES(CWT), .CLEAR_WAIT_CYCLES(CLW)
  ) dut (
    .clock(clock), .reset(reset), .lcd_text(lcd_text),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_on(lcd_on), .lcd_blon(lcd_blon), .init_done(init_done), .busy(busy)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  int rise_q[$];
  int fall_q[$];
  int n = 0;
  logic en_prev = 1'b0;
  logic busy_prev = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: one entry per lcd_en rising edge, timestamped in cycles since reset.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) n = 0; else n++;
      if (lcd_en && !en_prev) begin
        obs_q.push_back({lcd_rs, lcd_data});
        rise_q.push_back(n);
      end
      if (!lcd_en && en_prev && !reset && obs_q.size() > 0)
        check_val("hold", {23'd0, lcd_rs, lcd_data}, {23'd0, obs_q[obs_q.size()-1]});
      if (busy_prev && !busy) fall_q.push_back(n);
      en_prev   = lcd_en;
      busy_prev = busy;
    end
  end

  task automatic clear_q();
    obs_q.delete(); exp_q.delete(); rise_q.delete(); fall_q.delete();
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001); exp_q.push_back(9'h006);
  endtask

  // Expected display: skip leading NULs, left-justify, NUL and overflow -> space.
  task automatic push_refresh(input logic [255:0] t);
    int first;
    logic [7:0] b;
    first = 32;
    for (int i = 0; i < 32; i++)
      if (first == 32 && t[255-8*i -: 8] != 8'h00) first = i;
    exp_q.push_back(9'h080);
    for (int k = 0; k < 32; k++) begin
      if (k == 16) exp_q.push_back(9'h0C0);
      if (first + k > 31) b = 8'h20;
      else begin
        b = t[255-8*(first+k) -: 8];
        if (b == 8'h00) b = 8'h20;
      end
      exp_q.push_back({1'b1, b});
    end
  endtask

  task automatic wait_writes(input int cnt, input int budget);
    int left;
    left = budget;
    while (obs_q.size() < cnt && left > 0) begin
      @(negedge clock); #1;
      left--;
    end
    check_val("write_count", obs_q.size(), cnt);
  endtask

  task automatic wait_idle(input int budget);
    int left;
    left = budget;
    @(negedge clock);
    while (busy && left > 0) begin
      @(negedge clock);
      left--;
    end
    check_val("idle_reached", {31'd0, busy}, 32'd0);
    #1;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clock);
    #1;
  endtask

  // Bytes in order, plus spacing: each write lasts 7 or 13 cycles, and a
  // refresh start (0x80) follows one IDLE and one SNAP cycle.
  task automatic check_stream(input string tag);
    int gap;
    check_val({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_val($sformatf("%s_byte%0d", tag, i), {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
    for (int i = 1; i < exp_q.size() && i < rise_q.size(); i++) begin
      gap = (exp_q[i-1] == 9'h001) ? CLR : NORM;
      if (exp_q[i] == 9'h080) gap += 2;
      check_val($sformatf("%s_gap%0d", tag, i), rise_q[i] - rise_q[i-1], gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clock); #1;
    reset = 1'b1;
    wait_cycles(3);
    check_val("rst_en", {31'd0, lcd_en}, 0);
    check_val("rst_rs", {31'd0, lcd_rs}, 0);
    check_val("rst_data", {24'd0, lcd_data}, 0);
    check_val("rst_rw", {31'd0, lcd_rw}, 0);
    check_val("rst_on", {30'd0, lcd_on, lcd_blon}, 3);
    check_val("rst_init_done", {31'd0, init_done}, 0);
    check_val("rst_busy", {31'd0, busy}, 1);
    clear_q();
    reset = 1'b0;
  endtask

  task automatic run_text(input logic [255:0] t, input string tag);
    clear_q();
    lcd_text = t;
    push_refresh(t);
    wait_writes(34, 2000);
    wait_idle(200);
    check_stream(tag);
  endtask

  task automatic rand_text(output logic [255:0] t);
    int len;
    logic [7:0] b;
    do begin
      t = '0;
      len = $urandom_range(1, 32);
      for (int i = 32 - len; i < 32; i++) begin
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) b = 8'h00;
        t[255-8*i -: 8] = b;
      end
    end while (t == lcd_text);
  endtask

  logic [255:0] t_a, t_b;
  int cnt_before, left;

  initial begin
    // Power-up, init, and first refresh of an all-NUL bus.
    do_reset();
    push_init();
    push_refresh('0);
    wait_writes(38, 3000);
    wait_idle(300);
    check_stream("pwr");
    check_val("init_done", {31'd0, init_done}, 1);
    check_val("fall_count", fall_q.size(), 2);
    if (rise_q.size() >= 5 && fall_q.size() >= 2) begin
      check_val("first_write", rise_q[0], PU + 1);
      check_val("init_fall", fall_q[0], rise_q[3] - 1 + NORM);
      check_val("refresh_fall", fall_q[1], rise_q[4] - 1 + 34 * NORM);
    end

    // Short right-justified string.
    t_a = "Enter c_real.";
    run_text(t_a, "enter");
    if (obs_q.size() >= 34) begin
      check_val("enter_first", {23'd0, obs_q[1]}, {23'd0, 9'h145});
      check_val("enter_pad", {23'd0, obs_q[14]}, {23'd0, 9'h120});
    end

    // Full 32-character text.
    t_a = "0123456789ABCDEFGHIJKLMNOPQRSTUV";
    run_text(t_a, "full");

    for (int r = 0; r < 6; r++) begin
      rand_text(t_a);
      run_text(t_a, $sformatf("rand%0d", r));
    end

    // Text change part way through a refresh: old text completes, then one more.
    rand_text(t_a);
    clear_q();
    lcd_text = t_a;
    push_refresh(t_a);
    t_b = "Done.";
    push_refresh(t_b);
    wait_writes(7, 500);
    lcd_text = t_b;
    wait_writes(68, 3000);
    wait_idle(200);
    check_stream("midchg");
    wait_cycles(30);
    check_val("midchg_extra", obs_q.size(), 68);
    check_val("midchg_busy", {31'd0, busy}, 0);

    // Change that reverts before IDLE produces no further refresh.
    rand_text(t_a);
    clear_q();
    lcd_text = t_a;
    push_refresh(t_a);
    wait_writes(3, 500);
    rand_text(t_b);
    lcd_text = t_b;
    wait_writes(5, 500);
    lcd_text = t_a;
    wait_writes(34, 3000);
    wait_idle(200);
    check_stream("revert");
    wait_cycles(30);
    check_val("revert_extra", obs_q.size(), 34);

    // Stable text in IDLE: no strobes, not busy.
    cnt_before = obs_q.size();
    wait_cycles(1000);
    check_val("idle_writes", obs_q.size(), cnt_before);
    check_val("idle_busy", {31'd0, busy}, 0);
    check_val("idle_falls", fall_q.size(), 1);

    // Reset while lcd_en is high mid-refresh restarts everything.
    rand_text(t_a);
    clear_q();
    lcd_text = t_a;
    wait_writes(4, 500);
    left = 100;
    while (!lcd_en && left > 0) begin
      @(negedge clock);
      left--;
    end
    check_val("mid_en_seen", {31'd0, lcd_en}, 1);
    #1 reset = 1'b1;
    @(negedge clock);
    check_val("mid_rst_en", {31'd0, lcd_en}, 0);
    check_val("mid_rst_init_done", {31'd0, init_done}, 0);
    check_val("mid_rst_busy", {31'd0, busy}, 1);
    wait_cycles(2);
    clear_q();
    reset = 1'b0;
    push_init();
    push_refresh(t_a);
    wait_writes(38, 3000);
    wait_idle(300);
    check_stream("rerun");
    if (rise_q.size() > 0) check_val("rerun_first", rise_q[0], PU + 1);
    check_val("rerun_init_done", {31'd0, init_done}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
